// File: rtl/matrix_rd_seq_if.sv
// Beat-stream bundle between the read sequencer and its downstream consumer.
//   m_data  : beat payload
//   m_valid : beat present
//   m_ready : consumer accepts the beat this cycle
//   m_last  : final beat of a block-read command
// master modport is the producer (sequencer), slave modport the consumer.
interface matrix_rd_seq_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/matrix_rd_seq.sv
// Block-read sequencer for the distributed-RAM matrix buffer.
// Accepts a (base, length) command, walks the buffer read address with wrap-around,
// absorbs the buffer's 2-cycle read latency and streams the words out as valid/ready
// beats with a last flag through a 4-entry FIFO. Reads are only issued while
// in-flight reads plus FIFO occupancy stay below 4, so backpressure never drops data.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start_i         : command strobe, honoured only when idle
//   base_addr_i     : first word address, reduced modulo ADDR_NUM
//   len_i           : word count, 0 = no-op, clipped to ADDR_NUM
//   busy_o, done_o  : command in progress / one-cycle completion pulse
//   ram_addrb_o     : buffer read address
//   ram_doutb_i     : buffer read data, valid 2 cycles after the address
//   m_axis          : output beat stream (master side)
module matrix_rd_seq #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_NUM   = 32,
  parameter int unsigned ADNW       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADNW-1:0]       base_addr_i,
  input  logic [ADNW-1:0]       len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADNW-1:0]       ram_addrb_o,
  input  logic [DATA_WIDTH-1:0] ram_doutb_i,
  matrix_rd_seq_if.master       m_axis
);

  localparam int FifoDepth = 4;
  localparam logic [ADNW-1:0] AddrNum = ADNW'(ADDR_NUM);
  localparam logic [ADNW-1:0] AddrMax = ADNW'(ADDR_NUM - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q;
  logic [ADNW-1:0]       addr_q;
  logic [ADNW-1:0]       remaining_q;
  logic                  busy_q;
  logic                  done_q;
  // Valid/last pipeline mirroring the buffer's read latency.
  logic [1:0]            pipe_vld_q;
  logic [1:0]            pipe_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FifoDepth];
  logic                  fifo_last_q [FifoDepth];
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [2:0]            count_q;

  logic [ADNW-1:0] base_mod;
  logic [ADNW-1:0] len_eff;
  logic [2:0]      credit_used;
  logic            issue;
  logic            fifo_wr;
  logic            fifo_rd;
  logic            last_hs;

  always_comb begin
    base_mod    = base_addr_i % AddrNum;
    len_eff     = (len_i > AddrNum) ? AddrNum : len_i;
    // The stage-2 read is being written this cycle; it still holds its credit.
    credit_used = count_q + {2'b00, pipe_vld_q[0]} + {2'b00, pipe_vld_q[1]};
    issue       = (state_q == StIssue) && (credit_used < 3'd4);
    fifo_wr     = pipe_vld_q[1];
    fifo_rd     = (count_q != 3'd0) && m_axis.m_ready;
    last_hs     = fifo_rd && fifo_last_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      done_q      <= 1'b0;
      pipe_vld_q  <= {pipe_vld_q[0], issue};
      pipe_last_q <= {pipe_last_q[0], issue && (remaining_q == ADNW'(1))};

      case (state_q)
        StIdle: begin
          if (start_i && (len_eff != '0)) begin
            state_q     <= StIssue;
            addr_q      <= base_mod;
            remaining_q <= len_eff;
            busy_q      <= 1'b1;
          end
        end
        StIssue: begin
          if (issue) begin
            remaining_q <= remaining_q - ADNW'(1);
            // addr_q is the address presented this cycle; it holds after the final read.
            if (remaining_q == ADNW'(1)) begin
              state_q <= StDrain;
            end else begin
              addr_q <= (addr_q == AddrMax) ? '0 : addr_q + ADNW'(1);
            end
          end
        end
        StDrain: begin
          if (last_hs) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (fifo_wr) begin
        fifo_data_q[wr_ptr_q] <= ram_doutb_i;
        fifo_last_q[wr_ptr_q] <= pipe_last_q[1];
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (fifo_rd) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign ram_addrb_o    = addr_q;
  assign m_axis.m_data  = fifo_data_q[rd_ptr_q];
  assign m_axis.m_valid = (count_q != 3'd0);
  assign m_axis.m_last  = (count_q != 3'd0) && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_matrix_rd_seq.sv
module tb_matrix_rd_seq;
  localparam int Words = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  base_addr = '0;
  logic [5:0]  len = '0;
  logic        busy;
  logic        done;
  logic [5:0]  ram_addrb;
  logic [63:0] ram_doutb;

  matrix_rd_seq_if #(.DATA_WIDTH(64)) m_if ();

  matrix_rd_seq #(
    .DATA_WIDTH(64),
    .ADDR_NUM  (32),
    .ADNW      (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .base_addr_i(base_addr),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .ram_addrb_o(ram_addrb),
    .ram_doutb_i(ram_doutb),
    .m_axis     (m_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: address sampled at end of cycle c, data visible during c+2.
  logic [63:0] mem [Words];
  logic [63:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[ram_addrb[4:0]];
    rd2 <= rd1;
  end
  assign ram_doutb = rd2;

  // Ready generator: 0 high, 1 toggle, 2 low, 3 random.
  int ready_mode = 2;
  logic tog = 1'b0;
  always @(posedge clk) begin
    #2;
    tog = ~tog;
    case (ready_mode)
      0:       m_if.m_ready = 1'b1;
      1:       m_if.m_ready = tog;
      3:       m_if.m_ready = ($urandom_range(0, 3) != 0);
      default: m_if.m_ready = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;
  int n_beats = 0;

  // Reference model state: expected beats {last, data}, plus command timeline.
  logic [64:0] exp_q[$];
  int acc_cyc = -1;
  int end_cyc = -1;
  int done_cyc = -10;
  bit checking = 0;

  logic        stall_prev = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit model_idle();
    return (acc_cyc < 0) || (end_cyc >= 0 && cyc > end_cyc);
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      logic exp_busy, exp_done;
      logic [64:0] e;
      exp_busy = (acc_cyc >= 0) && (cyc > acc_cyc) && (end_cyc < 0 || cyc <= end_cyc);
      exp_done = (cyc == done_cyc);
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(exp_done));
      if (stall_prev) begin
        check("stall_valid", 64'(m_if.m_valid), 64'd1);
        check("stall_data", m_if.m_data, prev_data);
        check("stall_last", 64'(m_if.m_last), 64'(prev_last));
      end
      if (m_if.m_valid && m_if.m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)",
                   m_if.m_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_if.m_data, e[63:0]);
          check("beat_last", 64'(m_if.m_last), 64'(e[64]));
          if (e[64]) begin
            end_cyc  = cyc;
            done_cyc = cyc + 1;
          end
        end
      end
      stall_prev = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
      prev_last  = m_if.m_last;
    end
  end

  task automatic issue_cmd(input int b, input int l, output int s);
    int n, bm;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b1;
    base_addr = 6'(b);
    len = 6'(l);
    if (model_idle() && l != 0) begin
      n  = (l > Words) ? Words : l;
      bm = b % Words;
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[(bm + i) % Words]});
      acc_cyc = s;
      end_cyc = -1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (model_idle()) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after 3000 cycles expected idle (cycle %0d)", cyc);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic fill_linear();
    for (int k = 0; k < Words; k++) mem[k] = 64'(k);
  endtask

  initial begin
    int s, nb0, b, l;
    fill_linear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_addrb", 64'(ram_addrb), 64'd0);
    check("rst_valid", 64'(m_if.m_valid), 64'd0);
    check("rst_last", 64'(m_if.m_last), 64'd0);
    check("rst_data", m_if.m_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    checking = 1;
    ready_mode = 0;

    // Linear read with exact timing.
    issue_cmd(0, 8, s);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 8) check("lin_addrb", 64'(ram_addrb), 64'(k - 1));
      if (k == 3) check("lin_first_valid_early", 64'(m_if.m_valid), 64'd0);
      if (k == 4) begin
        check("lin_first_valid", 64'(m_if.m_valid), 64'd1);
        check("lin_first_data", m_if.m_data, 64'd0);
      end
      if (k == 11) check("lin_last", 64'(m_if.m_last), 64'd1);
      if (k == 12) check("lin_done", 64'(done), 64'd1);
    end
    wait_idle();

    // Wrap-around.
    issue_cmd(30, 4, s);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("wrap_addrb", 64'(ram_addrb), 64'((29 + k) % 32));
    end
    wait_idle();

    // Backpressure: toggle, then hold low.
    issue_cmd(3, 16, s);
    ready_mode = 1;
    repeat (12) @(posedge clk);
    ready_mode = 2;
    repeat (10) @(posedge clk);
    ready_mode = 0;
    wait_idle();

    // len = 0 is a no-op.
    nb0 = n_beats;
    issue_cmd(7, 0, s);
    repeat (8) @(posedge clk);
    check("len0_beats", 64'(n_beats - nb0), 64'd0);

    // len = 40 clips to 32 words.
    nb0 = n_beats;
    issue_cmd(0, 40, s);
    wait_idle();
    check("len40_beats", 64'(n_beats - nb0), 64'd32);

    // len = 1.
    issue_cmd(9, 1, s);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) check("len1_last", 64'(m_if.m_last), 64'd1);
      if (k == 5) check("len1_done", 64'(done), 64'd1);
    end
    wait_idle();

    // Collision: second start while busy is dropped.
    issue_cmd(0, 8, s);
    repeat (2) @(posedge clk);
    issue_cmd(5, 3, s);
    wait_idle();

    // Reset mid-command.
    nb0 = n_beats;
    issue_cmd(0, 16, s);
    for (int i = 0; i < 200 && (n_beats - nb0) < 6; i++) @(negedge clk);
    check("mid_beats_before_reset", 64'(n_beats - nb0), 64'd6);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ready_mode = 2;
    @(posedge clk);
    #1;
    exp_q.delete();
    acc_cyc = -1;
    end_cyc = -1;
    done_cyc = -10;
    stall_prev = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(m_if.m_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (6) @(posedge clk);
    issue_cmd(2, 3, s);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) check("post_rst_first", m_if.m_data, 64'd2);
    end
    wait_idle();

    // Randomized commands with random data, lengths and backpressure.
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < Words; k++) mem[k] = {$urandom, $urandom};
      ready_mode = $urandom_range(0, 3);
      b = $urandom_range(0, 63);
      l = $urandom_range(0, 45);
      issue_cmd(b, l, s);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        issue_cmd($urandom_range(0, 63), $urandom_range(1, 10), s);
      end
      if (ready_mode == 2) begin
        repeat (8) @(posedge clk);
        ready_mode = 3;
      end
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
